vector_checker: RTL and testbench
=================================

# vector_checker

Synthesizable, parametrised test-vector engine for on-chip self-test of small combinational or pipelined blocks. It holds a vector memory, drives stimulus into a device under test and compares the device's response against expected values under a per-bit care mask. It counts errors, records the first failing vector and reports pass/fail through a start/done handshake. It sits beside the block under test in the self-test wrapper and replaces simulation-only testbench checking.

## Interface
- `IN_W`, 3: stimulus width driven to the DUT.
- `OUT_W`, 1: DUT response width.
- `DEPTH`, 1024: vector memory entries; `AW = $clog2(DEPTH)`.
- `LATENCY`, 0: DUT cycles from input change to valid output, 0..15.
- `CNT_W`, 32: width of the error and vector counters.
- Derived: `VEC_W = IN_W + 2*OUT_W`. Word layout is {stim[IN_W], expected[OUT_W], care[OUT_W]}, with stim in the MSBs.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `load_en`, in, 1: writes `load_data` to `load_addr` this cycle. Ignored while `busy`.
- `load_addr`, in, AW: write address.
- `load_data`, in, VEC_W: vector word.
- `num_vec`, in, AW+1: number of vectors to run, 0..DEPTH. Sampled at start.
- `start`, in, 1: single-cycle pulse. Accepted only in IDLE or DONE.
- `stop_on_err`, in, 1: halt at the first mismatch. Sampled at start.
- `dut_in`, out, IN_W: registered stimulus.
- `dut_out`, in, OUT_W: DUT response.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run finished. Held until the next accepted start or reset.
- `pass`, out, 1: valid when `done`. Means no errors and all `num_vec` vectors checked.
- `err_count`, out, CNT_W: mismatch count. Saturates at all-ones.
- `vec_count`, out, CNT_W: vectors checked this run.
- `first_fail_valid`, out, 1: at least one mismatch this run.
- `first_fail_idx`, out, AW: index of the first mismatching vector.

## Operation
- FSM states: IDLE, READ, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE with `start`:
  - Latch `num_vec` and `stop_on_err`.
  - Clear `err_count`, `vec_count`, `first_fail_*` and `idx`.
  - Drop `done` and `pass`.
  - If `num_vec==0`, go to DONE with `pass=1`. Otherwise go to READ.
- READ: synchronous memory read of `idx`.
- APPLY:
  - `dut_in <= stim`.
  - Latch `expected` and `care`.
  - Load the wait counter with `LATENCY`.
  - Go to WAIT if `LATENCY>0`, else CHECK.
- WAIT: decrement the counter; go to CHECK when it reaches 1.
- CHECK:
  - Mismatch = |((dut_out ^ expected) & care).
  - `vec_count` increments every check.
  - On mismatch, `err_count` increments (saturating). If `first_fail_valid==0`, record `idx` and set `first_fail_valid`.
  - End of run when `idx+1==num_vec`, or when mismatch and `stop_on_err`. Then go to DONE with `pass = (err_count_next==0) && (vec_count_next==num_vec)`.
  - Otherwise `idx++` and go to READ.
- `care=0` bits never cause a mismatch. An all-zero care word always passes.
- `dut_in` holds its last value in DONE and IDLE.
- `load_en` with `busy=1` is dropped, so memory is unchanged. `start` with `busy=1` is ignored.
- Memory contents are not cleared by `reset`.

## Timing
- Reset values:
  - State IDLE, `dut_in=0`, `busy=0`, `done=0`, `pass=0`.
  - `err_count=0`, `vec_count=0`, `first_fail_valid=0`, `first_fail_idx=0`.
- `busy` rises the cycle after `start` is accepted. It falls on the same edge that `done` rises.
- Each vector takes `3+LATENCY` cycles (READ, APPLY, LATENCY×WAIT, CHECK).
- `dut_out` is sampled in CHECK, exactly `LATENCY` cycles after `dut_in` changes.
- A full run takes `num_vec*(3+LATENCY)` cycles from the accepting edge to `done` rising. For `num_vec==0` it takes 1 cycle.
- A load to address k written in the same cycle that READ reads k: the read returns old data (read-first).
- `reset` asserted mid-run: next state IDLE, all outputs at reset values, no `done`.

## Structure
- `vector_checker_pkg`: state enum `vc_state_t`, and field-offset functions `stim_lo`, `exp_lo`, `care_lo` of (IN_W, OUT_W).
- Sub-module `vector_mem`: DEPTH×VEC_W memory with one write port and one synchronous read-first read port.
- FSM, counters and compare logic live in `vector_checker`.

## Test plan
- **Functional match:** IN_W=3, OUT_W=1, LATENCY=0. DUT y=~b&~c|a&~b. Load all 8 correct vectors with care=1, start. Required: done after 24 cycles, `pass=1`, `err_count=0`, `vec_count=8`.
- **Injected errors:** same setup, flip expected at vectors 2 and 5. Required: `err_count=2`, `first_fail_idx=2`, `pass=0`, `vec_count=8`.
- **Stop on error:** `stop_on_err=1` with errors at vectors 2 and 5. Required: done after 9 cycles, `vec_count=3`, `err_count=1`, `pass=0`.
- **Mask and latency:** LATENCY=2, DUT registered twice. Expected wrong at vector 4 but care=0. Required: `pass=1`, 5 cycles per vector.
- **Zero vectors:** `num_vec=0`, start. Required: `done` 1 cycle later, `pass=1`, `vec_count=0`.
- **Reset and blocked inputs:** `reset` mid-run at vector 3 returns to IDLE with all outputs at reset values. While `busy`, `start` and `load_en` have no effect (memory readback unchanged).

Source files
------------

// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg: FSM state type and vector word field offsets shared by the checker.
package vector_checker_pkg;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_APPLY, S_WAIT, S_CHECK, S_DONE} vc_state_t;

    // Word layout is {stim, expected, care} with stim in the MSBs.
    function automatic int vec_w(input int in_w, input int out_w);
        return in_w + 2 * out_w;
    endfunction

    function automatic int stim_lo(input int in_w, input int out_w);
        return vec_w(in_w, out_w) - in_w;
    endfunction

    function automatic int exp_lo(input int in_w, input int out_w);
        return stim_lo(in_w, out_w) - out_w;
    endfunction

    function automatic int care_lo(input int in_w, input int out_w);
        return exp_lo(in_w, out_w) - out_w;
    endfunction

endpackage

// File: rtl/vector_mem.sv
// vector_mem: DEPTH x W vector store, one write port and one synchronous read-first read port.
module vector_mem #(
    parameter int DEPTH = 1024,
    parameter int W = 5,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/vector_checker.sv
// vector_checker: replays stored vectors into a block under test and checks its response
// under a per-bit care mask, reporting error count, first failure and pass/fail.
module vector_checker
    import vector_checker_pkg::*;
#(
    parameter int IN_W = 3,
    parameter int OUT_W = 1,
    parameter int DEPTH = 1024,
    parameter int LATENCY = 0,
    parameter int CNT_W = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int VEC_W = IN_W + 2 * OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [VEC_W-1:0] load_data,
    input  logic [AW:0]      num_vec,
    input  logic             start,
    input  logic             stop_on_err,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic             first_fail_valid,
    output logic [AW-1:0]    first_fail_idx
);
    localparam int SL = stim_lo(IN_W, OUT_W);
    localparam int EL = exp_lo(IN_W, OUT_W);
    localparam int CL = care_lo(IN_W, OUT_W);

    vc_state_t state, state_n;
    logic [AW:0] num_q;
    logic stop_q;
    logic [AW-1:0] idx;
    logic [OUT_W-1:0] exp_q, care_q;
    logic [3:0] wcnt;
    logic [VEC_W-1:0] rdata;
    logic start_ok, mism, last;
    logic [CNT_W-1:0] err_n, vec_n;

    assign busy = !(state == S_IDLE || state == S_DONE);
    assign done = state == S_DONE;
    assign start_ok = start && !busy;
    assign mism = |((dut_out ^ exp_q) & care_q);
    assign err_n = err_count + CNT_W'(mism && !(&err_count));
    assign vec_n = vec_count + CNT_W'(1);
    assign last = ({1'b0, idx} + (AW+1)'(1) == num_q) || (mism && stop_q);

    vector_mem #(.DEPTH(DEPTH), .W(VEC_W)) u_mem (
        .clk(clk),
        .we(load_en && !busy),
        .waddr(load_addr),
        .wdata(load_data),
        .re(state == S_READ),
        .raddr(idx),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: if (start_ok) state_n = (num_vec == '0) ? S_DONE : S_READ;
            S_READ:  state_n = S_APPLY;
            S_APPLY: state_n = (LATENCY > 0) ? S_WAIT : S_CHECK;
            S_WAIT:  state_n = (wcnt == 4'd1) ? S_CHECK : S_WAIT;
            S_CHECK: state_n = last ? S_DONE : S_READ;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dut_in <= '0;
            pass <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx <= '0;
            idx <= '0;
            num_q <= '0;
            stop_q <= 1'b0;
            exp_q <= '0;
            care_q <= '0;
            wcnt <= '0;
        end else begin
            if (start_ok) begin
                num_q <= num_vec;
                stop_q <= stop_on_err;
                err_count <= '0;
                vec_count <= '0;
                first_fail_valid <= 1'b0;
                first_fail_idx <= '0;
                idx <= '0;
                pass <= num_vec == '0;
            end
            if (state == S_APPLY) begin
                dut_in <= rdata[SL +: IN_W];
                exp_q <= rdata[EL +: OUT_W];
                care_q <= rdata[CL +: OUT_W];
                wcnt <= 4'(LATENCY);
            end
            if (state == S_WAIT) wcnt <= wcnt - 4'd1;
            // Counters and pass use the post-check values so the final vector is included.
            if (state == S_CHECK) begin
                vec_count <= vec_n;
                err_count <= err_n;
                if (mism && !first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx <= idx;
                end
                if (last) pass <= (err_n == '0) && (vec_n == CNT_W'(num_q));
                else idx <= idx + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: scoreboard bench; stimulus queues expected run results, a monitor
// compares them whenever a checker raises done.
module tb_vector_checker;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    typedef struct {
        string name;
        int acc;
        logic pass;
        int err;
        int vec;
        logic ffv;
        int ffi;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset, le0, le2, st0, st2, stop;
    logic [AW-1:0] la;
    logic [4:0] ld;
    logic [AW:0] nv;
    logic [2:0] din0, din2;
    logic y0, y2, r1, r2;
    logic busy0, done0, pass0, ffv0, busy2, done2, pass2, ffv2;
    logic [31:0] err0, vec0, err2, vec2;
    logic [AW-1:0] ffi0, ffi2;
    logic [7:0] ytab = 8'b0011_0001;
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    exp_t q0[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic f(input logic [2:0] s);
        return (~s[1] & ~s[0]) | (s[2] & ~s[1]);
    endfunction

    assign y0 = f(din0);
    always @(posedge clk) begin
        r1 <= f(din2);
        r2 <= r1;
    end
    assign y2 = r2;

    vector_checker #(.IN_W(3), .OUT_W(1), .DEPTH(DEPTH), .LATENCY(0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .load_en(le0), .load_addr(la), .load_data(ld),
        .num_vec(nv), .start(st0), .stop_on_err(stop), .dut_in(din0), .dut_out(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0),
        .first_fail_valid(ffv0), .first_fail_idx(ffi0)
    );

    vector_checker #(.IN_W(3), .OUT_W(1), .DEPTH(DEPTH), .LATENCY(2), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .load_en(le2), .load_addr(la), .load_data(ld),
        .num_vec(nv), .start(st2), .stop_on_err(stop), .dut_in(din2), .dut_out(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_count(vec2),
        .first_fail_valid(ffv2), .first_fail_idx(ffi2)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, expv);
        end
    endtask

    function automatic exp_t mk(input string n, input logic p, input int er, input int ve,
                                input logic fv, input int fi, input int cy);
        exp_t e;
        e.name = n; e.acc = 0; e.pass = p; e.err = er; e.vec = ve;
        e.ffv = fv; e.ffi = fi; e.cyc = cy;
        return e;
    endfunction

    function automatic logic [4:0] vw(input int i, input logic flip, input logic care);
        logic [2:0] s;
        s = i[2:0];
        return {s, ytab[i] ^ flip, care};
    endfunction

    task automatic score(input exp_t e, input logic p, input logic [31:0] er, input logic [31:0] ve,
                         input logic fv, input logic [AW-1:0] fi);
        chk({e.name, ".pass"}, 64'(p), 64'(e.pass));
        chk({e.name, ".err_count"}, 64'(er), 64'(e.err));
        chk({e.name, ".vec_count"}, 64'(ve), 64'(e.vec));
        chk({e.name, ".ff_valid"}, 64'(fv), 64'(e.ffv));
        if (e.ffv) chk({e.name, ".ff_idx"}, 64'(fi), 64'(e.ffi));
        chk({e.name, ".cycles"}, 64'(cyc - e.acc), 64'(e.cyc));
    endtask

    // Monitor: a rising done must match the oldest queued expectation for that checker.
    initial begin
        exp_t e;
        logic p0, p2;
        p0 = 1'b0;
        p2 = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 === 1'b1 && !p0) begin
                if (q0.size() == 0) chk("dut0.unexpected_done", 64'(done0), 64'(0));
                else begin
                    e = q0.pop_front();
                    score(e, pass0, err0, vec0, ffv0, ffi0);
                end
            end
            if (done2 === 1'b1 && !p2) begin
                if (q2.size() == 0) chk("dut2.unexpected_done", 64'(done2), 64'(0));
                else begin
                    e = q2.pop_front();
                    score(e, pass2, err2, vec2, ffv2, ffi2);
                end
            end
            p0 = done0 === 1'b1;
            p2 = done2 === 1'b1;
        end
    end

    task automatic load(input int w, input int a, input logic [4:0] d);
        la = a[AW-1:0];
        ld = d;
        if (w == 2) le2 = 1'b1;
        else le0 = 1'b1;
        @(negedge clk);
        le0 = 1'b0;
        le2 = 1'b0;
    endtask

    // e.cyc counts edges from the accepting edge to the edge on which done rises.
    task automatic begin_run(input int w, input exp_t e, input int num, input logic so);
        nv = num[AW:0];
        stop = so;
        e.acc = cyc + 1;
        if (w == 2) begin
            q2.push_back(e);
            st2 = 1'b1;
        end else begin
            q0.push_back(e);
            st0 = 1'b1;
        end
        @(negedge clk);
        st0 = 1'b0;
        st2 = 1'b0;
    endtask

    task automatic wait_done(input int w, input string n);
        for (int k = 0; k < 400 && !((w == 2) ? done2 : done0); k++) @(negedge clk);
        if (!((w == 2) ? done2 : done0)) chk({n, ".timeout_done"}, 64'(0), 64'(1));
        @(negedge clk);
    endtask

    task automatic chk_idle0(input string n);
        chk({n, ".dut_in"}, 64'(din0), 64'(0));
        chk({n, ".busy"}, 64'(busy0), 64'(0));
        chk({n, ".done"}, 64'(done0), 64'(0));
        chk({n, ".pass"}, 64'(pass0), 64'(0));
        chk({n, ".err_count"}, 64'(err0), 64'(0));
        chk({n, ".vec_count"}, 64'(vec0), 64'(0));
        chk({n, ".ff_valid"}, 64'(ffv0), 64'(0));
        chk({n, ".ff_idx"}, 64'(ffi0), 64'(0));
    endtask

    initial begin
        reset = 1'b1; le0 = 1'b0; le2 = 1'b0; st0 = 1'b0; st2 = 1'b0; stop = 1'b0;
        la = '0; ld = '0; nv = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle0("reset");
        chk("reset.dut2_busy", 64'(busy2), 64'(0));

        begin_run(0, mk("zero", 1'b1, 0, 0, 1'b0, 0, 0), 0, 1'b0);
        chk("zero.done_next_cycle", 64'(done0), 64'(1));
        wait_done(0, "zero");

        for (int i = 0; i < 8; i++) load(0, i, vw(i, 1'b0, 1'b1));
        begin_run(0, mk("match", 1'b1, 0, 8, 1'b0, 0, 24), 8, 1'b0);
        wait_done(0, "match");
        chk("match.dut_in_hold", 64'(din0), 64'(7));
        repeat (3) @(negedge clk);
        chk("match.dut_in_hold_later", 64'(din0), 64'(7));
        chk("match.done_held", 64'(done0), 64'(1));

        for (int i = 0; i < 8; i++) load(0, i, vw(i, i == 2 || i == 5, 1'b1));
        begin_run(0, mk("inject", 1'b0, 2, 8, 1'b1, 2, 24), 8, 1'b0);
        wait_done(0, "inject");

        begin_run(0, mk("stop", 1'b0, 1, 3, 1'b1, 2, 9), 8, 1'b1);
        wait_done(0, "stop");

        // Reset during vector 3, after vector 2 has already failed.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nv = 8; stop = 1'b0; st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst.busy_before", 64'(busy0), 64'(1));
        chk("midrst.err_before", 64'(err0), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle0("midrst");
        repeat (30) @(negedge clk);
        chk("midrst.stays_idle", 64'(busy0), 64'(0));

        for (int i = 0; i < 8; i++) load(0, i, vw(i, 1'b0, 1'b1));
        begin_run(0, mk("blocked", 1'b1, 0, 8, 1'b0, 0, 24), 8, 1'b0);
        repeat (2) @(negedge clk);
        chk("blocked.busy", 64'(busy0), 64'(1));
        load(0, 6, vw(6, 1'b1, 1'b1));
        nv = 0; st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        nv = 8;
        wait_done(0, "blocked");
        begin_run(0, mk("rerun", 1'b1, 0, 8, 1'b0, 0, 24), 8, 1'b0);
        wait_done(0, "rerun");

        for (int i = 0; i < 8; i++) load(2, i, (i == 4) ? vw(i, 1'b1, 1'b0) : vw(i, 1'b0, 1'b1));
        begin_run(2, mk("latency", 1'b1, 0, 8, 1'b0, 0, 40), 8, 1'b0);
        wait_done(2, "latency");

        chk("q0.drained", 64'(q0.size()), 64'(0));
        chk("q2.drained", 64'(q2.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
